// File: rtl/register_dump_reader.sv
// register_dump_reader
//
// Debug readout engine for the general register file. A Start pulse in IDLE walks the
// register addresses FIRST_REG..LAST_REG through one combinational register-file read
// port. Each value is streamed out as one beat on a valid/ready channel.
//
// The sequence for each register is FETCH (the address is driven and the data captured)
// followed by SEND (the beat is held until the handshake). With DumpReady held high this
// gives at most one beat every two cycles.
//
// Optional feature, selected by the macro DUMP_CHECKSUM_EN:
//   When the macro is defined, a running XOR of every dumped value is accumulated. After
//   the LAST_REG beat, one extra beat carries that XOR with DumpChecksum=1 and
//   DumpLast=1. When the macro is undefined, DumpChecksum is tied to 0 and DumpLast marks
//   the LAST_REG beat.
//
// Ports
//   Clock           in   rising-edge clock
//   Reset           in   asynchronous, active-high reset
//   Start           in   begin a dump (sampled only in IDLE)
//   Abort           in   terminate the current dump; no Done pulse
//   ReadRegAddress  out  address to the register-file read port (holds outside FETCH)
//   ReadData        in   combinational read data for ReadRegAddress
//   DumpData        out  beat payload (registered)
//   DumpIndex       out  register address of the current beat
//   DumpValid       out  beat valid
//   DumpReady       in   sink accepts the beat when DumpValid & DumpReady
//   DumpLast        out  final beat of the dump
//   DumpChecksum    out  beat carries the checksum
//   Busy            out  high in every state except IDLE
//   Done            out  one-cycle pulse after the final beat handshake
//
// Parameters must satisfy FIRST_REG <= LAST_REG <= 2**ADDR_WIDTH-1.

module register_dump_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned FIRST_REG  = 0,
  parameter int unsigned LAST_REG   = 31
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Abort,
  output logic [ADDR_WIDTH-1:0] ReadRegAddress,
  input  logic [DATA_WIDTH-1:0] ReadData,
  output logic [DATA_WIDTH-1:0] DumpData,
  output logic [ADDR_WIDTH-1:0] DumpIndex,
  output logic                  DumpValid,
  input  logic                  DumpReady,
  output logic                  DumpLast,
  output logic                  DumpChecksum,
  output logic                  Busy,
  output logic                  Done
);

  localparam logic [ADDR_WIDTH-1:0] FirstAddr = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(LAST_REG);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StFetch, StSend, StCsum} stateT;
`else
  typedef enum logic [1:0] {StIdle, StFetch, StSend} stateT;
`endif

  stateT                 stateQ, stateD;
  logic [ADDR_WIDTH-1:0] indexQ, indexD;
  logic [DATA_WIDTH-1:0] dataQ, dataD;
  logic [ADDR_WIDTH-1:0] dumpIndexQ, dumpIndexD;
  logic                  lastQ, lastD;
  logic                  doneQ, doneD;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csumQ, csumD;
  logic                  csumFlagQ, csumFlagD;
`endif

  logic atLast;
  logic handshake;

  assign atLast    = (indexQ == LastAddr);
  assign handshake = DumpValid & DumpReady;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateQ     <= StIdle;
      indexQ     <= '0;
      dataQ      <= '0;
      dumpIndexQ <= '0;
      lastQ      <= 1'b0;
      doneQ      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csumQ      <= '0;
      csumFlagQ  <= 1'b0;
`endif
    end else begin
      stateQ     <= stateD;
      indexQ     <= indexD;
      dataQ      <= dataD;
      dumpIndexQ <= dumpIndexD;
      lastQ      <= lastD;
      doneQ      <= doneD;
`ifdef DUMP_CHECKSUM_EN
      csumQ      <= csumD;
      csumFlagQ  <= csumFlagD;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    stateD     = stateQ;
    indexD     = indexQ;
    dataD      = dataQ;
    dumpIndexD = dumpIndexQ;
    lastD      = lastQ;
    doneD      = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    csumD      = csumQ;
    csumFlagD  = csumFlagQ;
`endif

    if (Abort) begin
      // Abort wins over every transition. A beat accepted in this same cycle is
      // still counted as delivered by the sink, but no Done is raised.
      stateD = StIdle;
`ifdef DUMP_CHECKSUM_EN
      csumFlagD = 1'b0;
`endif
    end else begin
      case (stateQ)
        StIdle: begin
          if (Start) begin
            indexD = FirstAddr;
            stateD = StFetch;
`ifdef DUMP_CHECKSUM_EN
            csumD  = '0;
`endif
          end
        end

        StFetch: begin
          // ReadRegAddress is indexQ here; the read port answers in the same cycle.
          dataD      = ReadData;
          dumpIndexD = indexQ;
`ifdef DUMP_CHECKSUM_EN
          // The checksum beat follows, so no register beat is marked last.
          lastD      = 1'b0;
          csumD      = csumQ ^ ReadData;
          csumFlagD  = 1'b0;
`else
          lastD      = atLast;
`endif
          stateD     = StSend;
        end

        StSend: begin
          if (handshake) begin
            if (!atLast) begin
              // The index only advances below LAST_REG, so it can never wrap.
              indexD = indexQ + ADDR_WIDTH'(1);
              stateD = StFetch;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              // csumQ already includes the LAST_REG value, which was folded in at FETCH.
              dataD     = csumQ;
              lastD     = 1'b1;
              csumFlagD = 1'b1;
              stateD    = StCsum;
`else
              doneD  = 1'b1;
              stateD = StIdle;
`endif
            end
          end
        end

`ifdef DUMP_CHECKSUM_EN
        StCsum: begin
          if (handshake) begin
            csumFlagD = 1'b0;
            doneD     = 1'b1;
            stateD    = StIdle;
          end
        end
`endif

        default: begin
          stateD = StIdle;
        end
      endcase
    end
  end

  // Outputs. The index register drives the read port directly: it only changes when
  // entering FETCH, so the address holds its last value everywhere else.
  assign ReadRegAddress = indexQ;
  assign DumpData       = dataQ;
  assign DumpIndex      = dumpIndexQ;
  assign DumpLast       = lastQ;
  assign Busy           = (stateQ != StIdle);
  assign Done           = doneQ;

`ifdef DUMP_CHECKSUM_EN
  assign DumpValid    = (stateQ == StSend) || (stateQ == StCsum);
  assign DumpChecksum = csumFlagQ;
`else
  assign DumpValid    = (stateQ == StSend);
  assign DumpChecksum = 1'b0;
`endif

endmodule

// File: tb/tb_register_dump_reader.sv
// tb_register_dump_reader
//
// Randomized bench for register_dump_reader. A behavioural register file answers
// ReadRegAddress combinationally. The expected beat list for each dump is built from the
// register contents. A negedge monitor scores every accepted beat, the Done timing, and
// the beat stability under back-pressure.

module tb_register_dump_reader;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned FIRST = 0;
  localparam int unsigned LAST  = 31;

  logic          Clock;
  logic          Reset;
  logic          Start;
  logic          Abort;
  logic [AW-1:0] ReadRegAddress;
  logic [DW-1:0] ReadData;
  logic [DW-1:0] DumpData;
  logic [AW-1:0] DumpIndex;
  logic          DumpValid;
  logic          DumpReady;
  logic          DumpLast;
  logic          DumpChecksum;
  logic          Busy;
  logic          Done;

  logic [DW-1:0] regFile [32];

  assign ReadData = regFile[ReadRegAddress];

  register_dump_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIRST_REG (FIRST),
    .LAST_REG  (LAST)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Start         (Start),
    .Abort         (Abort),
    .ReadRegAddress(ReadRegAddress),
    .ReadData      (ReadData),
    .DumpData      (DumpData),
    .DumpIndex     (DumpIndex),
    .DumpValid     (DumpValid),
    .DumpReady     (DumpReady),
    .DumpLast      (DumpLast),
    .DumpChecksum  (DumpChecksum),
    .Busy          (Busy),
    .Done          (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
    logic          csum;
    logic          fin;
  } beatT;

  beatT          expQ[$];
  int            checks;
  int            errors;
  int            doneCount;
  bit            monOn;
  int            readyMode;
  int            stallCnt;
  bit            repulse;
  bit            abortArmed;
  bit            abortFired;
  logic [DW-1:0] csumSeen;

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected beats come straight from the register contents and the dump rules.
  function automatic void buildExpected();
    logic [DW-1:0] x;
    x = '0;
    expQ.delete();
    for (int a = FIRST; a <= LAST; a++) begin
      beatT b;
      b.idx  = AW'(a);
      b.data = regFile[a];
      b.csum = 1'b0;
      x      = x ^ regFile[a];
`ifdef DUMP_CHECKSUM_EN
      b.last = 1'b0;
      b.fin  = 1'b0;
`else
      b.last = (a == LAST);
      b.fin  = (a == LAST);
`endif
      expQ.push_back(b);
    end
`ifdef DUMP_CHECKSUM_EN
    begin
      beatT c;
      c.idx  = AW'(LAST);
      c.data = x;
      c.last = 1'b1;
      c.csum = 1'b1;
      c.fin  = 1'b1;
      expQ.push_back(c);
    end
`endif
  endfunction

  // Advance one cycle and drive all inputs 1 time unit after the rising edge.
  task automatic stepCycle();
    @(posedge Clock);
    #1;
    Start = 1'b0;
    Abort = 1'b0;
    case (readyMode)
      0: DumpReady = 1'b1;
      1: DumpReady = ($urandom_range(0, 3) != 0);
      default: begin
        if (DumpValid && DumpIndex == AW'(3) && stallCnt < 5) begin
          DumpReady = 1'b0;
          stallCnt++;
        end else begin
          DumpReady = 1'b1;
        end
      end
    endcase
    if (repulse && DumpValid && (DumpIndex == AW'(4) || DumpIndex == AW'(10))) Start = 1'b1;
    if (abortArmed && DumpValid && DumpIndex == AW'(7)) begin
      Abort      = 1'b1;
      abortArmed = 1'b0;
      abortFired = 1'b1;
    end
  endtask

  // Pulse Start from IDLE and check the two-cycle latency to the first valid beat.
  task automatic startDump();
    buildExpected();
    doneCount = 0;
    Start = 1'b1;
    stepCycle();
    @(negedge Clock);
    checkValue("latFetchValid", 64'(DumpValid), 64'(0));
    checkValue("latBusy", 64'(Busy), 64'(1));
    stepCycle();
    @(negedge Clock);
    checkValue("latValid", 64'(DumpValid), 64'(1));
  endtask

  task automatic runDump();
    int n;
    n = 0;
    while (doneCount == 0 && n < 400) begin
      stepCycle();
      n++;
    end
    checkValue("dumpTimeout", 64'(n < 400), 64'(1));
    repeat (3) stepCycle();
    checkValue("beatsLeft", 64'(expQ.size()), 64'(0));
    checkValue("doneCount", 64'(doneCount), 64'(1));
    checkValue("idleBusy", 64'(Busy), 64'(0));
  endtask

  task automatic checkAllZero();
    checkValue("rstAddr", 64'(ReadRegAddress), 64'(0));
    checkValue("rstData", 64'(DumpData), 64'(0));
    checkValue("rstIndex", 64'(DumpIndex), 64'(0));
    checkValue("rstValid", 64'(DumpValid), 64'(0));
    checkValue("rstLast", 64'(DumpLast), 64'(0));
    checkValue("rstCsum", 64'(DumpChecksum), 64'(0));
    checkValue("rstBusy", 64'(Busy), 64'(0));
    checkValue("rstDone", 64'(Done), 64'(0));
  endtask

  // Monitor: scores beats, Done timing, abort response and back-pressure stability.
  initial begin
    logic          prevValid, prevReady, prevAbort, prevLast, prevCsum, doneExp, nextDone;
    logic [DW-1:0] prevData;
    logic [AW-1:0] prevIdx;
    beatT          b;
    prevValid = 1'b0; prevReady = 1'b0; prevAbort = 1'b0; prevLast = 1'b0;
    prevCsum  = 1'b0; doneExp = 1'b0; prevData = '0; prevIdx = '0;
    forever begin
      @(negedge Clock);
      if (!monOn) begin
        prevValid = 1'b0;
        prevAbort = 1'b0;
        doneExp   = 1'b0;
      end else begin
        checkValue("done", 64'(Done), 64'(doneExp));
        if (Done) doneCount++;
        if (prevAbort) begin
          checkValue("abortValid", 64'(DumpValid), 64'(0));
          checkValue("abortBusy", 64'(Busy), 64'(0));
        end
        if (prevValid && !prevReady && !prevAbort) begin
          checkValue("holdValid", 64'(DumpValid), 64'(1));
          checkValue("holdData", 64'(DumpData), 64'(prevData));
          checkValue("holdIndex", 64'(DumpIndex), 64'(prevIdx));
          checkValue("holdLast", 64'(DumpLast), 64'(prevLast));
          checkValue("holdCsum", 64'(DumpChecksum), 64'(prevCsum));
        end
        nextDone = 1'b0;
        if (DumpValid) begin
          checkValue("addrHold", 64'(ReadRegAddress), 64'(DumpIndex));
          if (DumpReady) begin
            if (expQ.size() == 0) begin
              checkValue("extraBeat", 64'(DumpIndex), 64'(32'hFFFF_FFFF));
            end else begin
              b = expQ.pop_front();
              checkValue("beatIndex", 64'(DumpIndex), 64'(b.idx));
              checkValue("beatData", 64'(DumpData), 64'(b.data));
              checkValue("beatLast", 64'(DumpLast), 64'(b.last));
              checkValue("beatCsum", 64'(DumpChecksum), 64'(b.csum));
              if (b.csum) csumSeen = DumpData;
              nextDone = b.fin && !Abort;
            end
          end
        end
        doneExp   = nextDone;
        prevValid = DumpValid;
        prevReady = DumpReady;
        prevAbort = Abort;
        prevData  = DumpData;
        prevIdx   = DumpIndex;
        prevLast  = DumpLast;
        prevCsum  = DumpChecksum;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    checks = 0; errors = 0; doneCount = 0; monOn = 1'b0; readyMode = 0; stallCnt = 0;
    repulse = 1'b0; abortArmed = 1'b0; abortFired = 1'b0; csumSeen = '0;
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; DumpReady = 1'b0;
    for (int i = 0; i < 32; i++) regFile[i] = '0;

    // Reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checkAllZero();
    stepCycle();
    Reset = 1'b0;
    monOn = 1'b1;
    stepCycle();

    // Ramp pattern, sink always ready
    for (int i = 0; i < 32; i++) regFile[i] = 32'(i) * 32'h11;
    readyMode = 0;
    startDump();
    runDump();

    // Back-pressure on beat 3
    readyMode = 2;
    stallCnt  = 0;
    startDump();
    runDump();
    checkValue("stallCycles", 64'(stallCnt), 64'(5));

    // Start re-pulsed mid-dump is ignored
    readyMode = 1;
    repulse   = 1'b1;
    startDump();
    runDump();
    repulse = 1'b0;

    // Abort on beat 7, then restart from the first register
    readyMode  = 0;
    abortArmed = 1'b1;
    abortFired = 1'b0;
    startDump();
    n = 0;
    while (!abortFired && n < 200) begin
      stepCycle();
      n++;
    end
    checkValue("abortReached", 64'(abortFired), 64'(1));
    repeat (6) stepCycle();
    checkValue("abortNoDone", 64'(doneCount), 64'(0));
    checkValue("abortIdle", 64'(Busy), 64'(0));
    expQ.delete();
    startDump();
    runDump();

    // Asynchronous reset at beat 12
    readyMode = 1;
    startDump();
    n = 0;
    while (!(DumpValid && DumpIndex == AW'(12)) && n < 200) begin
      stepCycle();
      n++;
    end
    checkValue("beat12Reached", 64'(n < 200), 64'(1));
    #2;
    Reset = 1'b1;
    monOn = 1'b0;
    #1;
    checkAllZero();
    repeat (2) stepCycle();
    Reset = 1'b0;
    expQ.delete();
    monOn = 1'b1;
    stepCycle();
    startDump();
    runDump();

    // Random register contents under random back-pressure
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) regFile[i] = $urandom;
      startDump();
      runDump();
    end

`ifdef DUMP_CHECKSUM_EN
    // Checksum of two complementary halves
    for (int i = 0; i < 32; i++) regFile[i] = '0;
    regFile[1] = 32'hA5A5_0000;
    regFile[2] = 32'h0000_5A5A;
    readyMode  = 0;
    startDump();
    runDump();
    checkValue("csumValue", 64'(csumSeen), 64'(32'hA5A5_5A5A));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
